// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : serial_adder_ctrl_if
// Brief    : start/done request handshake and result bus of the bit-serial adder.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, in1, in2, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, in1, in2, c_in,
    output busy, done, sum, c_out
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : serial_adder_ctrl
// Brief    : Bit-serial adder sequencer; one full-adder slice, one bit per clock.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int                c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_sum_sr;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_c_out;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_accept;
  logic               w_last;
  logic               w_ha1_s;
  logic               w_ha1_c;
  logic               w_ha2_c;
  logic               w_s;
  logic               w_carry_nxt;
  logic [WIDTH-1:0]   w_sum_nxt;

  // Shared full-adder slice built from two half adders and an OR gate.
  assign w_ha1_s     = r_a_sr[0] ^ r_b_sr[0];
  assign w_ha1_c     = r_a_sr[0] & r_b_sr[0];
  assign w_s         = w_ha1_s ^ r_carry;
  assign w_ha2_c     = w_ha1_s & r_carry;
  assign w_carry_nxt = w_ha1_c | w_ha2_c;

  assign w_sum_nxt = (r_sum_sr >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
  assign w_last    = (r_cnt == c_CNT_LAST);
  assign w_accept  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_ADD;
      S_ADD:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_ADD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_c_out  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr  <= bus.in1;
      r_b_sr  <= bus.in2;
      r_carry <= bus.c_in;
      r_cnt   <= '0;
    end else if (r_state == S_ADD) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_carry  <= w_carry_nxt;
      r_sum_sr <= w_sum_nxt;
      r_cnt    <= r_cnt + c_CNT_W'(1);
      // Result is published only on the DONE transition and then held.
      if (w_last) begin
        r_sum   <= w_sum_nxt;
        r_c_out <= w_carry_nxt;
      end
    end
  end

  assign bus.busy  = (r_state == S_ADD);
  assign bus.done  = (r_state == S_DONE);
  assign bus.sum   = r_sum;
  assign bus.c_out = r_c_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_serial_adder_ctrl
// Brief    : Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request yields its sum after W busy cycles.
  int           m_left    = 0;
  logic         m_done    = 1'b0;
  logic [W-1:0] m_sum     = '0;
  logic         m_cout    = 1'b0;
  logic [W:0]   m_pend    = '0;
  int           m_accepts = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) {m_cout, m_sum} <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_left    <= W;
        m_pend    <= {1'b0, bus.in1} + {1'b0, bus.in2} + (W+1)'(bus.c_in);
        m_accepts <= m_accepts + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy",  32'(bus.busy),  32'(m_left > 0));
      check("done",  32'(bus.done),  32'(m_done));
      check("sum",   32'(bus.sum),   32'(m_sum));
      check("c_out", 32'(bus.c_out), 32'(m_cout));
      if (bus.done) n_done++;
    end
  end

  // Called at a falling edge; returns at the falling edge of busy cycle 1.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    bus.c_in  = c;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns at the falling edge where done is high, or flags a timeout.
  task automatic wait_done(output int busy_cnt, output bit ok);
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        return;
      end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] esum, input logic ecout, input string name);
    int bc;
    bit ok;
    start_op(a, b, c);
    wait_done(bc, ok);
    if (ok) begin
      check({name, "_sum"},   32'(bus.sum),   32'(esum));
      check({name, "_c_out"}, 32'(bus.c_out), 32'(ecout));
      check({name, "_busy_cycles"}, 32'(bc), 32'd8);
    end
  endtask

  initial begin
    int          bc;
    bit          ok;
    int          gap;
    int          acc0;
    int          done0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    bus.c_in  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_sum",   32'(bus.sum),   32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_op(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, "t1");
    @(negedge clk);
    do_op(8'd255, 8'd1, 1'b0, 8'd0, 1'b1, "t2a");
    @(negedge clk);
    do_op(8'd0, 8'd0, 1'b1, 8'd1, 1'b0, "t2b");
    @(negedge clk);

    // Start held high through ADD; operands change on the 3rd busy cycle.
    bus.start = 1'b1;
    bus.in1   = 8'd10;
    bus.in2   = 8'd20;
    bus.c_in  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t3_busy", 32'(bus.busy), 32'd1);
      if (i == 2) begin
        bus.in1 = 8'd99;
        bus.in2 = 8'd99;
      end
      if (i == 7) bus.start = 1'b0;
    end
    @(negedge clk);
    check("t3_done",  32'(bus.done),  32'd1);
    check("t3_sum",   32'(bus.sum),   32'd30);
    check("t3_c_out", 32'(bus.c_out), 32'd0);
    @(negedge clk);
    check("t3_no_restart", 32'(bus.busy), 32'd0);

    // Abort with reset on the 4th busy cycle.
    start_op(8'd200, 8'd100, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_busy",  32'(bus.busy),  32'd0);
    check("t4_done",  32'(bus.done),  32'd0);
    check("t4_sum",   32'(bus.sum),   32'd0);
    check("t4_c_out", 32'(bus.c_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t4_no_done", 32'(bus.done), 32'd0);
    end

    // Back-to-back accept on the DONE cycle.
    start_op(8'd1, 8'd2, 1'b0);
    wait_done(bc, ok);
    check("t5a_sum", 32'(bus.sum), 32'd3);
    start_op(8'd15, 8'd240, 1'b0);
    check("t5_no_idle", 32'(bus.busy), 32'd1);
    wait_done(bc, ok);
    if (ok) begin
      check("t5_sum",   32'(bus.sum),   32'd255);
      check("t5_c_out", 32'(bus.c_out), 32'd0);
      check("t5_busy_cycles", 32'(bc), 32'd8);
    end
    @(negedge clk);

    // Random traffic with gaps of 0..3 idle cycles (0 = back-to-back).
    acc0  = m_accepts;
    done0 = n_done;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      start_op(ra, rb, rc);
      wait_done(bc, ok);
      if (ok) check("t6_result", 32'({bus.c_out, bus.sum}), 32'({1'b0, ra} + {1'b0, rb} + 9'(rc)));
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("t6_done_count", 32'(n_done - done0), 32'(m_accepts - acc0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
